// File: rtl/stepper_motion_unit_if.sv
// Command/status bundle between the stepper controller FSM (master) and the
// motion unit (slave).
interface stepper_motion_unit_if #(
  parameter int POS_WIDTH   = 8,
  parameter int DELAY_WIDTH = 8
);
  logic                   start;
  logic                   abort;
  logic                   load_pos;
  logic [POS_WIDTH-1:0]   target;
  logic [DELAY_WIDTH-1:0] delay;
  logic [1:0]             mode;
  logic                   busy;
  logic                   done;
  logic                   aborted;
  logic [POS_WIDTH-1:0]   position;
  logic [3:0]             stepper_signals;

  modport master (
    output start, abort, load_pos, target, delay, mode,
    input  busy, done, aborted, position, stepper_signals
  );

  modport slave (
    input  start, abort, load_pos, target, delay, mode,
    output busy, done, aborted, position, stepper_signals
  );
endinterface

// File: rtl/stepper_motion_unit.sv
// Stepper motion engine: moves along the shortest circular path to a target,
// pacing steps with a prescaled delay counter and driving four coil lines.
module stepper_motion_unit #(
  parameter int POS_WIDTH   = 8,
  parameter int DELAY_WIDTH = 8,
  parameter int PRESCALE    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stepper_motion_unit_if.slave bus
);

  localparam int                     PRE_WIDTH  = $clog2(PRESCALE) + 1;
  localparam logic [PRE_WIDTH-1:0]   PRE_RELOAD = PRE_WIDTH'(PRESCALE - 1);
  localparam logic [PRE_WIDTH-1:0]   PRE_ZERO   = {PRE_WIDTH{1'b0}};
  localparam logic [PRE_WIDTH-1:0]   PRE_ONE    = PRE_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_ZERO = {DELAY_WIDTH{1'b0}};
  localparam logic [DELAY_WIDTH-1:0] DELAY_ONE  = DELAY_WIDTH'(1);
  localparam logic [POS_WIDTH-1:0]   POS_ZERO   = {POS_WIDTH{1'b0}};
  localparam logic [POS_WIDTH-1:0]   POS_ONE    = POS_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t                 state_q;
  logic [POS_WIDTH-1:0]   pos_q;
  logic [POS_WIDTH-1:0]   tgt_q;
  logic [2:0]             ph_q;
  logic [3:0]             coil_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
  logic                   dir_fwd_q;
  logic [1:0]             mode_q;
  logic [DELAY_WIDTH-1:0] dly_q;
  logic [DELAY_WIDTH-1:0] cnt_q;
  logic [PRE_WIDTH-1:0]   pre_q;

  logic [POS_WIDTH-1:0]   diff_d;
  logic [POS_WIDTH-1:0]   pos_d;
  logic [2:0]             ph_d;
  logic [DELAY_WIDTH-1:0] dly_d;

  // Reserved mode 2'b11 falls through to the full-step table.
  function automatic logic [3:0] coil_pattern(input logic [1:0] md, input logic [2:0] ph);
    logic [3:0] pat;
    pat = 4'b0000;
    case (md)
      2'b01: begin
        case (ph)
          3'd0:    pat = 4'b1000;
          3'd1:    pat = 4'b1100;
          3'd2:    pat = 4'b0100;
          3'd3:    pat = 4'b0110;
          3'd4:    pat = 4'b0010;
          3'd5:    pat = 4'b0011;
          3'd6:    pat = 4'b0001;
          3'd7:    pat = 4'b1001;
          default: pat = 4'b0000;
        endcase
      end
      2'b10: begin
        case (ph[2:1])
          2'd0:    pat = 4'b1000;
          2'd1:    pat = 4'b0100;
          2'd2:    pat = 4'b0010;
          2'd3:    pat = 4'b0001;
          default: pat = 4'b0000;
        endcase
      end
      default: begin
        case (ph[2:1])
          2'd0:    pat = 4'b1100;
          2'd1:    pat = 4'b0110;
          2'd2:    pat = 4'b0011;
          2'd3:    pat = 4'b1001;
          default: pat = 4'b0000;
        endcase
      end
    endcase
    return pat;
  endfunction

  function automatic logic [2:0] phase_advance(input logic [1:0] md, input logic [2:0] ph,
                                               input logic fwd);
    logic [2:0] stride;
    stride = (md == 2'b01) ? 3'd1 : 3'd2;
    return fwd ? (ph + stride) : (ph - stride);
  endfunction

  // Distance to the requested target and the position/phase one step on.
  always_comb begin
    diff_d = bus.target - pos_q;
    dly_d  = (bus.delay == DELAY_ZERO) ? DELAY_ONE : bus.delay;
    if (dir_fwd_q) begin
      pos_d = pos_q + POS_ONE;
    end else begin
      pos_d = pos_q - POS_ONE;
    end
    ph_d = phase_advance(mode_q, ph_q, dir_fwd_q);
  end

  // Motion FSM with registered status and coil outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pos_q     <= POS_ZERO;
      tgt_q     <= POS_ZERO;
      ph_q      <= 3'd0;
      coil_q    <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      dir_fwd_q <= 1'b1;
      mode_q    <= 2'b00;
      dly_q     <= DELAY_ONE;
      cnt_q     <= DELAY_ONE;
      pre_q     <= PRE_ZERO;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
          end else if (bus.load_pos) begin
            pos_q <= bus.target;
          end else if (bus.start) begin
            tgt_q     <= bus.target;
            mode_q    <= bus.mode;
            dly_q     <= dly_d;
            // A half-revolution tie has MSB set and therefore goes backward.
            dir_fwd_q <= ~diff_d[POS_WIDTH-1];
            coil_q    <= coil_pattern(bus.mode, ph_q);
            if (diff_d == POS_ZERO) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              busy_q  <= 1'b1;
              cnt_q   <= dly_d;
              pre_q   <= PRE_RELOAD;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (pre_q == PRE_ZERO) begin
            pre_q <= PRE_RELOAD;
            if (cnt_q == DELAY_ONE) begin
              state_q <= ST_STEP;
            end else begin
              cnt_q <= cnt_q - DELAY_ONE;
            end
          end else begin
            pre_q <= pre_q - PRE_ONE;
          end
        end
        ST_STEP: begin
          // The step commits even when abort arrives on this edge.
          ph_q   <= ph_d;
          pos_q  <= pos_d;
          coil_q <= coil_pattern(mode_q, ph_d);
          if (bus.abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (pos_d == tgt_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= dly_q;
            pre_q   <= PRE_RELOAD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.aborted         = aborted_q;
  assign bus.position        = pos_q;
  assign bus.stepper_signals = coil_q;

endmodule
